// File: rtl/power_q10.sv
// power_q10: iterative Q10.10 power unit, base^n (n 0..7) via serial shift-add multiplies with saturation.
module power_q10 #(
  parameter int          W    = 20,
  parameter int          FRAC = 10,
  parameter logic [19:0] ONE  = 20'h00400
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data_1,
  input  logic [2:0]   in_data_2,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_overflow
);
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_NORM, ST_OUTPUT} state_t;
  state_t           state_q, state_d;
  logic [W-1:0]     base_q, base_d, acc_q, acc_d;
  logic [2:0]       rem_q, rem_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [2*W-1:0]   part_q, part_d;
  logic             ovf_q, ovf_d;
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    part_d  = part_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: if (in_valid) begin
        base_d  = in_data_1;
        acc_d   = (in_data_2 == 3'd0) ? ONE : in_data_1;
        rem_d   = in_data_2 - 3'd1;
        cnt_d   = '0;
        part_d  = '0;
        ovf_d   = 1'b0;
        state_d = (in_data_2 < 3'd2) ? ST_OUTPUT : ST_MUL;
      end
      ST_MUL: begin
        // multiplier bits come from the base, the running result is the multiplicand
        part_d  = base_q[cnt_q] ? part_q + ({{W{1'b0}}, acc_q} << cnt_q) : part_q;
        cnt_d   = cnt_q + 5'd1;
        state_d = (cnt_q == 5'(W-1)) ? ST_NORM : ST_MUL;
      end
      ST_NORM: if (|part_q[2*W-1:W+FRAC]) begin
        acc_d   = '1;
        ovf_d   = 1'b1;
        state_d = ST_OUTPUT;
      end else begin
        acc_d   = part_q[W+FRAC-1:FRAC];
        rem_d   = rem_q - 3'd1;
        part_d  = '0;
        cnt_d   = '0;
        state_d = (rem_q == 3'd1) ? ST_OUTPUT : ST_MUL;
      end
      default: begin
        ovf_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      part_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      part_q  <= part_d;
      ovf_q   <= ovf_d;
    end
  end
  assign out_valid    = (state_q == ST_OUTPUT);
  assign out_data     = out_valid ? acc_q : '0;
  assign out_overflow = out_valid & ovf_q;
endmodule
